// File: rtl/rr_arbiter_8way_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arb_pkg;
    localparam int ARB_N               = 8;
    localparam int ARB_IDX_W           = 3;
    localparam int ARB_TIMEOUT_DEFAULT = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;
endpackage

// File: rtl/rr_arbiter_8way_if.sv
// Request/grant bundle between eight clients and the arbiter.
// Latency: n/a (wires only).
// Backpressure: clients hold req until granted; done ends ownership.
// Ports: master = client side (drives req/done), slave = arbiter side.
interface rr_arbiter_8way_if
    import arb_pkg::*;
();
    logic [ARB_N-1:0]     req;
    logic                 done;
    logic [ARB_N-1:0]     gnt;
    logic [ARB_IDX_W-1:0] gnt_idx;
    logic                 gnt_valid;
    logic                 timeout;

    modport master (
        output req, done,
        input  gnt, gnt_idx, gnt_valid, timeout
    );

    modport slave (
        input  req, done,
        output gnt, gnt_idx, gnt_valid, timeout
    );
endinterface

// File: rtl/rr_arbiter_8way_pick8.sv
// Rotating-priority picker: first set request at or after ptr, modulo 8.
// Latency: purely combinational.
// Backpressure: none; the caller registers the result.
// Ports: req[7:0], ptr[2:0] in; winner[2:0], any out.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [ARB_N-1:0]     req,
    input  logic [ARB_IDX_W-1:0] ptr,
    output logic [ARB_IDX_W-1:0] winner,
    output logic                 any
);
    logic [ARB_IDX_W-1:0] idx;

    always_comb begin
        winner = '0;
        idx    = '0;
        any    = |req;
        // Scan from the farthest offset down so the nearest match to ptr
        // is the last assignment and therefore wins.
        for (int i = ARB_N - 1; i >= 0; i--) begin
            idx = ptr + ARB_IDX_W'(i);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end
endmodule

// File: rtl/rr_arbiter_8way.sv
// Eight-client round-robin arbiter holding a one-hot grant until release.
// Latency: grant one cycle after req seen in IDLE; release one cycle after done.
// Backpressure: non-owner requests ignored while busy; clients must hold req.
// Ports: clk, rst (sync, active high), bus (rr_arbiter_8way_if.slave).
// Build option: define ARB_TIMEOUT_EN to force release after TIMEOUT_CYCLES.
module rr_arbiter_8way
    import arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    rr_arbiter_8way_if.slave   bus
);
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("rr_arbiter_8way: TIMEOUT_CYCLES out of range 2..65535");
    end

    arb_state_e           state_q,   state_d;
    logic [ARB_IDX_W-1:0] ptr_q,     ptr_d;
    logic [ARB_N-1:0]     gnt_q,     gnt_d;
    logic [ARB_IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [ARB_IDX_W-1:0] winner;
    logic                 any;
    logic                 norm_rel;
    logic                 forced_rel;
`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] HOLD_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]          cnt_q,     cnt_d;
    logic                 timeout_q, timeout_d;
`endif

    rr_pick8 u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .winner (winner),
        .any    (any)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        // Abandonment and done collapse into a single release.
        norm_rel   = bus.done | ~bus.req[gnt_idx_q];
`ifdef ARB_TIMEOUT_EN
        forced_rel = ~norm_rel & (cnt_q == HOLD_LAST);
`else
        forced_rel = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (any) begin
                    state_d   = GRANT;
                    gnt_idx_d = winner;
                    gnt_d     = ARB_N'(1) << winner;
`ifdef ARB_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            GRANT: begin
                if (norm_rel | forced_rel) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = gnt_idx_q + 1'b1;
`ifdef ARB_TIMEOUT_EN
                    timeout_d = forced_rel;
`endif
                end else begin
`ifdef ARB_TIMEOUT_EN
                    cnt_d = cnt_q + 16'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.gnt_valid = (state_q == GRANT);
`ifdef ARB_TIMEOUT_EN
    assign bus.timeout   = timeout_q;
`else
    assign bus.timeout   = 1'b0;
`endif
endmodule

// File: doc/rr_arbiter_8way.md
# rr_arbiter_8way

Eight-requester round-robin arbiter that shares a single downstream resource among eight clients. It holds a one-hot grant, plus its 3-bit binary index, until the owner signals completion. Priority then rotates to the next index after the last owner. It sits between the request lines of the eight clients and the resource's select/enable logic, whose one-hot select the grant drives directly.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16, maximum cycles a grant may be held before forced release (used only with ARB_TIMEOUT_EN; legal 2..65535)

Ports:
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous, active-high reset
- req  input  8  request per client; bit i = client i; level-sensitive
- done  input  1  current owner finishes; valid only while gnt_valid=1
- gnt  output  8  one-hot grant; all-zero when idle
- gnt_idx  output  3  binary index of the granted client; holds last value when idle
- gnt_valid  output  1  high while any grant is active
- timeout  output  1  one-cycle pulse on forced release

## Operation
- Reset values: gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0, internal pointer ptr=3'd0, state=IDLE, hold counter=0.
- State machine with two states, IDLE and GRANT.
- IDLE: if req≠0, select the first set bit scanning ptr, ptr+1, … ptr+7 (mod 8). Register gnt_idx=winner and gnt=1<<winner, set gnt_valid=1, and go to GRANT. If req=0, stay in IDLE.
- GRANT: outputs are held stable. Release occurs on any of the following:
  - done=1;
  - req[gnt_idx]=0 (owner abandons);
  - timeout (see Configuration).
- On release: gnt=0, gnt_valid=0, ptr=gnt_idx+1 (3-bit wrap, 7→0), return to IDLE. gnt_idx keeps its value.
- Requests from non-owners during GRANT are ignored. They are not latched, so a client must hold req until granted.
- done while in IDLE is ignored.
- done and req[gnt_idx]=0 in the same cycle count as one release.
- Simultaneous done and a new request from any client: the release is taken first. The new request is arbitrated in the following IDLE cycle.
- Index arithmetic is modulo 8 throughout; no client is ever granted twice in a row while another client holds req continuously.
- rst during GRANT: the next edge forces all reset values. Any in-progress grant is dropped with no timeout pulse.

## Timing
- Arbitration latency: req sampled at edge k in IDLE → gnt/gnt_valid high after edge k (registered, visible in cycle k+1).
- Release latency: done sampled at edge m → gnt low after edge m.
- Minimum one IDLE cycle between consecutive grants. Back-to-back throughput is one grant per (hold cycles + 1).
- gnt and gnt_idx are registered outputs with no combinational path from req or done.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A 16-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When the counter equals TIMEOUT_CYCLES-1 and no other release occurs, the arbiter forces a release.
  - The forced release pulses timeout=1 for the cycle following the release edge and advances ptr as for a normal release.
  - A normal release on the same cycle takes precedence, with no timeout pulse.
- ARB_TIMEOUT_EN undefined: no counter; grants last until done or the owner drops req; timeout is tied to 0. The port list is identical in both builds.

## Structure
- Shared package arb_pkg:
  - state enum {IDLE, GRANT};
  - constants ARB_N=8 and ARB_IDX_W=3;
  - the default timeout constant.
- One sub-module, rr_pick8: combinational rotating-priority picker. Inputs req[7:0] and ptr[2:0]; outputs winner[2:0] and any. The top level registers its result and expands winner to one-hot.

## Test plan
- Reset then req=8'h00 for 5 cycles → gnt=8'h00, gnt_valid=0, timeout=0 throughout.
- Single client: req=8'h10 from reset, done after 3 GRANT cycles → gnt=8'h10, gnt_idx=4, held exactly 3 cycles; ptr becomes 5.
- Rotation: req=8'hFF held, done pulsed every GRANT cycle → grant order 0,1,…,7,0 with one IDLE cycle between each.
- Wrap and skip: ptr=7, req=8'h05 → grant idx 0 (gnt=8'h01), then idx 2 (8'h04), then idx 0.
- Owner abandons: granted idx 3 drops req[3] with no done → gnt=0 on the next cycle and the next grant goes to the first requester at or after idx 4.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=4, req=8'h02 held, no done → gnt=8'h02 for 4 cycles, then forced release with timeout=1 for one cycle. Also assert rst mid-grant in a separate run → all reset values on the next cycle and timeout stays 0.
